// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer behind the vend FSM core.
// Queues sell decisions (one change bit per entry) in a small FIFO and, per entry, pulses the
// drink motor, waits for the drop sensor, optionally pulses the change-coin motor and waits for
// the coin sensor, then holds an inter-dispense gap. A missing sensor ack latches a fault that
// only clr_fault releases.
// Ports:
//   clk, rst_                  clock, asynchronous active-low reset
//   pulse_i, sell_i, change_i  decision strobe from the vend core; push on pulse_i & sell_i
//   drop_sensor, coin_sensor   actuation acknowledges
//   clr_fault                  single-cycle fault clear
//   drink_motor, coin_motor    motor drives (registered)
//   busy, fault                sequencer not idle / latched timeout fault
//   coin_inhibit, ovf          FIFO full / sticky dropped-decision flag
//   served_cnt                 completed dispenses, wrapping
module vend_dispense_ctrl #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MOTOR_CYC = 8,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned GAP       = 2
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       pulse_i,
  input  logic       sell_i,
  input  logic       change_i,
  input  logic       drop_sensor,
  input  logic       coin_sensor,
  input  logic       clr_fault,
  output logic       drink_motor,
  output logic       coin_motor,
  output logic       busy,
  output logic       fault,
  output logic       coin_inhibit,
  output logic       ovf,
  output logic [7:0] served_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MaxMg = (MOTOR_CYC > GAP) ? MOTOR_CYC : GAP;
  localparam int unsigned MaxCyc = (MaxMg > TIMEOUT) ? MaxMg : TIMEOUT;
  localparam int unsigned CW = $clog2(MaxCyc + 1);

  localparam logic [CW-1:0] MotorLast   = CW'(MOTOR_CYC - 1);
  localparam logic [CW-1:0] TimeoutLast = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GapLast     = CW'(GAP - 1);
  localparam logic [AW:0]   FullCount   = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    StIdle, StDrink, StWaitDrop, StChange, StWaitCoin, StGap, StFault
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              chg_q, chg_d;
  logic [DEPTH-1:0]  mem_q, mem_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        served_q, served_d;
  logic              drink_q, coin_q, busy_q, fault_q, inhibit_q;

  logic push, full, pop, push_ok;

  // FIFO bookkeeping; pop only looks at the registered count so a push into an empty FIFO
  // is never consumed in the same cycle.
  always_comb begin
    push     = pulse_i & sell_i;
    full     = (count_q == FullCount);
    pop      = (state_q == StIdle) && (count_q != '0);
    push_ok  = push && (!full || pop);
    ovf_d    = ovf_q | (push && full && !pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    chg_d    = chg_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = change_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      chg_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (pop) state_d = StDrink;
      StDrink:    if (cnt_q == MotorLast) state_d = StWaitDrop;
      StWaitDrop: begin
        if (drop_sensor || ack_q) begin
          state_d = chg_q ? StChange : StGap;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StFault;
        end
      end
      StChange:   if (cnt_q == MotorLast) state_d = StWaitCoin;
      StWaitCoin: begin
        if (coin_sensor || ack_q) begin
          state_d = StGap;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StFault;
        end
      end
      StGap:      if (cnt_q == GapLast) state_d = StIdle;
      StFault:    if (clr_fault) state_d = StIdle;
      default:    state_d = StIdle;
    endcase

    // Counter restarts on every state entry.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StIdle || state_q == StFault) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Early ack is only collected while the matching motor runs; it is consumed on the first
    // wait cycle, so it never leaks into the next actuation.
    unique case (state_q)
      StDrink:  ack_d = ack_q | drop_sensor;
      StChange: ack_d = ack_q | coin_sensor;
      default:  ack_d = 1'b0;
    endcase

    served_d = served_q;
    if (state_d == StGap && state_q != StGap) begin
      served_d = served_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      chg_q     <= 1'b0;
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      served_q  <= '0;
      drink_q   <= 1'b0;
      coin_q    <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      inhibit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      chg_q     <= chg_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      served_q  <= served_d;
      // Outputs registered from next state so they line up with state_q.
      drink_q   <= (state_d == StDrink);
      coin_q    <= (state_d == StChange);
      busy_q    <= (state_d != StIdle);
      fault_q   <= (state_d == StFault);
      inhibit_q <= (count_d == FullCount);
    end
  end

  assign drink_motor  = drink_q;
  assign coin_motor   = coin_q;
  assign busy         = busy_q;
  assign fault        = fault_q;
  assign coin_inhibit = inhibit_q;
  assign ovf          = ovf_q;
  assign served_cnt   = served_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
module tb_vend_dispense_ctrl;

  localparam int MotorCyc = 8;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       pulse_i = 1'b0, sell_i = 1'b0, change_i = 1'b0;
  logic       drop_sensor = 1'b0, coin_sensor = 1'b0, clr_fault = 1'b0;
  logic       drink_motor, coin_motor, busy, fault, coin_inhibit, ovf;
  logic [7:0] served_cnt;

  vend_dispense_ctrl #(
    .DEPTH(4), .MOTOR_CYC(8), .TIMEOUT(64), .GAP(2)
  ) dut (
    .clk(clk), .rst_(rst_), .pulse_i(pulse_i), .sell_i(sell_i), .change_i(change_i),
    .drop_sensor(drop_sensor), .coin_sensor(coin_sensor), .clr_fault(clr_fault),
    .drink_motor(drink_motor), .coin_motor(coin_motor), .busy(busy), .fault(fault),
    .coin_inhibit(coin_inhibit), .ovf(ovf), .served_cnt(served_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard: change bit of each accepted decision, in dispense order.
  logic sb[$];

  // Sensor responder.
  bit ack_en = 1'b0;
  bit early_drop = 1'b0;
  int ack_dly = 3;
  int dcd = -1, ccd = -1;
  logic r_drink_prev = 1'b0, r_coin_prev = 1'b0;

  always @(negedge clk) begin
    drop_sensor = 1'b0;
    coin_sensor = 1'b0;
    if (!rst_) begin
      dcd = -1; ccd = -1; r_drink_prev = 1'b0; r_coin_prev = 1'b0;
    end else begin
      if (ack_en) begin
        if (early_drop && drink_motor && !r_drink_prev) dcd = 2;
        if (!early_drop && !drink_motor && r_drink_prev) dcd = ack_dly;
        if (!coin_motor && r_coin_prev) ccd = ack_dly;
      end
      if (dcd == 0) drop_sensor = 1'b1;
      if (dcd >= 0) dcd--;
      if (ccd == 0) coin_sensor = 1'b1;
      if (ccd >= 0) ccd--;
      r_drink_prev = drink_motor;
      r_coin_prev  = coin_motor;
    end
  end

  // Output monitor: pops the scoreboard when a dispense starts, checks pulse widths,
  // served count steps and whether the coin motor ran for the entry.
  logic       m_drink_prev = 1'b0, m_coin_prev = 1'b0, saw_coin = 1'b0, cur_chg = 1'b0;
  logic [7:0] m_served_prev = '0, exp_served = '0;
  int         dlen = 0, clen = 0;

  always @(negedge clk) begin
    if (!rst_) begin
      m_drink_prev = 1'b0; m_coin_prev = 1'b0; saw_coin = 1'b0; cur_chg = 1'b0;
      m_served_prev = '0; exp_served = '0; dlen = 0; clen = 0;
    end else begin
      if (drink_motor && !m_drink_prev) begin
        check_eq("entry_queued_at_pop", sb.size() != 0, 1);
        if (sb.size() != 0) cur_chg = sb.pop_front();
        dlen = 0;
        saw_coin = 1'b0;
      end
      if (drink_motor) dlen++;
      if (!drink_motor && m_drink_prev) check_eq("drink_len", dlen, MotorCyc);
      if (coin_motor && !m_coin_prev) begin
        saw_coin = 1'b1;
        clen = 0;
      end
      if (coin_motor) clen++;
      if (!coin_motor && m_coin_prev) check_eq("coin_len", clen, MotorCyc);
      if (served_cnt != m_served_prev) begin
        exp_served = exp_served + 8'd1;
        check_eq("served_step", served_cnt, exp_served);
        check_eq("change_path", saw_coin, cur_chg);
      end
      m_drink_prev  = drink_motor;
      m_coin_prev   = coin_motor;
      m_served_prev = served_cnt;
    end
  end

  // Call at a negedge; drives one decision cycle and returns at the next negedge.
  task automatic push(input logic chg, input bit accepted);
    pulse_i = 1'b1; sell_i = 1'b1; change_i = chg;
    if (accepted) sb.push_back(chg);
    @(negedge clk);
    pulse_i = 1'b0; sell_i = 1'b0; change_i = 1'b0;
  endtask

  task automatic wait_drink(input logic lvl, input int budget);
    int n = 0;
    while (drink_motor !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_drink_level", drink_motor, lvl);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drained_to_idle", (sb.size() == 0) && (busy === 1'b0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] s0;
    #1 rst_ = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_outputs",
             {drink_motor, coin_motor, busy, fault, coin_inhibit, ovf, served_cnt}, 0);
    rst_ = 1'b1;
    @(negedge clk);

    // Single sell, no change; a strobe without sell must not queue anything.
    ack_en = 1'b1;
    pulse_i = 1'b1; change_i = 1'b1;
    @(negedge clk);
    pulse_i = 1'b0; change_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("no_sell_no_busy", busy, 0);
    push(1'b0, 1'b1);
    n = 0;
    while (served_cnt != 8'd1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("single_served", served_cnt, 1);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_eq("gap_len", n, 2);
    check_eq("single_idle", busy, 0);

    // Sell with change.
    push(1'b1, 1'b1);
    wait_idle(300);
    check_eq("change_served", served_cnt, 2);

    // Back-to-back overflow: sixth decision finds the FIFO full while in DRINK.
    check_eq("ovf_before", ovf, 0);
    for (int i = 0; i < 6; i++) begin
      push(((i % 3) != 1), (i < 5));
      check_eq($sformatf("inhibit_after_push%0d", i), coin_inhibit, (i >= 4));
    end
    check_eq("ovf_set", ovf, 1);
    wait_idle(1000);
    check_eq("ovf_sticky", ovf, 1);
    check_eq("inhibit_clear", coin_inhibit, 0);
    check_eq("ovf_served", served_cnt, 7);

    // Timeout into fault, push accepted while faulted, then clear.
    ack_en = 1'b0;
    s0 = served_cnt;
    push(1'b0, 1'b1);
    wait_drink(1'b1, 20);
    wait_drink(1'b0, 20);
    n = 1;
    while (!fault && n < 200) begin
      @(negedge clk);
      if (!fault) n++;
    end
    check_eq("wait_drop_len", n, 64);
    check_eq("fault_set", fault, 1);
    check_eq("fault_motors", {drink_motor, coin_motor}, 0);
    push(1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("fault_holds", {fault, drink_motor, busy}, 3'b101);
    ack_en = 1'b1;
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    check_eq("fault_cleared", fault, 0);
    wait_idle(300);
    check_eq("after_fault_served", served_cnt, s0 + 8'd1);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    check_eq("clr_outside_fault", {busy, fault}, 0);

    // Early drop ack, then reset in the middle of CHANGE.
    early_drop = 1'b1;
    push(1'b1, 1'b1);
    wait_drink(1'b1, 20);
    wait_drink(1'b0, 20);
    @(negedge clk);
    check_eq("early_ack_to_change", coin_motor, 1);
    repeat (3) @(negedge clk);
    #2 rst_ = 1'b0;
    #1 check_eq("async_coin_off", coin_motor, 0);
    sb.delete();
    early_drop = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_mid_outputs", {busy, fault, coin_inhibit, ovf, drink_motor, served_cnt}, 0);
    rst_ = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("fifo_flushed", busy, 0);

    // Wrap after 256 dispenses.
    ack_dly = 1;
    for (int i = 0; i < 256; i++) begin
      push(((i % 4) == 0), 1'b1);
      wait_idle(300);
    end
    check_eq("served_wrap", served_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
- Sequences the physical dispense path behind the vend FSM core.
- Captures each sell/change decision in a small FIFO and drives the drink motor, then the change-coin motor, with timed pulses.
- Waits for a sensor acknowledge after each pulse and enters a latched fault on timeout.
- Asserts coin_inhibit upstream when it cannot accept more decisions.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
MOTOR_CYC, 8, cycles each motor output is held high per actuation (>=1)
TIMEOUT, 64, max cycles to wait for a sensor ack after a motor pulse (>=1)
GAP, 2, idle cycles between consecutive completed dispenses (>=1)

Ports:
clk  input  1  clock
rst_  input  1  asynchronous active-low reset
pulse_i  input  1  coin strobe; same cycle as the vend core's sell/change evaluation
sell_i  input  1  vend core sell (combinational, valid when pulse_i=1)
change_i  input  1  vend core change (valid when pulse_i=1)
drop_sensor  input  1  drink-drop sensor, one or more cycles high
coin_sensor  input  1  change-coin sensor, one or more cycles high
clr_fault  input  1  single-cycle fault clear
drink_motor  output  1  drink motor drive
coin_motor  output  1  change-coin motor drive
busy  output  1  FSM not in IDLE
fault  output  1  latched timeout fault
coin_inhibit  output  1  FIFO full; upstream must block coin entry
ovf  output  1  sticky: a decision was dropped
served_cnt  output  8  completed dispenses, wraps 255->0

Behaviour:
- Reset state:
  - Reset is rst_, asynchronous, active-low; clock is clk.
  - On reset, all outputs are 0, the FIFO is empty and the FSM is in IDLE.
  - A reset mid-operation aborts any motor pulse immediately and discards queued entries.
- All outputs are registered.
- Push:
  - A push occurs on a cycle with pulse_i & sell_i. Entry data is the change_i bit.
  - If the FIFO is full and no pop happens that cycle, the entry is dropped and ovf is set. ovf clears only on reset.
  - Push and pop in the same cycle while full: both take effect; no overflow.
- coin_inhibit = count==DEPTH, registered. It updates the cycle after the push that fills the FIFO.
- FSM states: IDLE, DRINK, WAIT_DROP, CHANGE, WAIT_COIN, GAP, FAULT.
- IDLE:
  - If the FIFO is non-empty, pop the head and go to DRINK on the next edge.
  - A push into an empty FIFO is popped no earlier than the following cycle; no bypass.
- DRINK:
  - drink_motor=1 for exactly MOTOR_CYC cycles, then go to WAIT_DROP.
  - A drop_sensor seen during DRINK is latched as an ack.
- WAIT_DROP:
  - On drop_sensor, or an ack latched in DRINK, go to CHANGE if the popped entry's change bit=1, else go to GAP.
  - If TIMEOUT cycles elapse with no ack, go to FAULT.
  - The ack check has priority over timeout in the same cycle.
- CHANGE / WAIT_COIN: identical to DRINK / WAIT_DROP, using coin_motor and coin_sensor. On ack, go to GAP.
- GAP:
  - Increment served_cnt on entry.
  - Stay GAP cycles, then return to IDLE.
- FAULT:
  - fault=1 and both motors are 0. The FIFO keeps its contents and still accepts pushes.
  - The failed entry is lost and served_cnt is not incremented.
  - clr_fault goes to IDLE; fault drops the next cycle.
  - clr_fault outside FAULT is ignored.
- busy = state != IDLE.
- Sensor edges in states other than DRINK, WAIT_DROP, CHANGE and WAIT_COIN are ignored. A sensor level that remains high from a previous ack does not count as a new ack until the matching motor has started.
- Timeout and motor counters are sized ceil(log2(max(MOTOR_CYC,TIMEOUT,GAP)+1)) bits and reset on each state entry.

Test Plan:
- Single sell, no change:
  - Stimulus: pulse_i=sell_i=1, change_i=0 for 1 cycle. drop_sensor pulses 3 cycles after drink_motor falls.
  - Required: drink_motor high exactly 8 cycles; coin_motor never high; GAP 2 cycles; served_cnt=1; busy low afterwards.
- Sell with change:
  - Stimulus: one push with change_i=1. Ack drop_sensor, then coin_sensor.
  - Required: drink_motor 8 cycles, then coin_motor 8 cycles; served_cnt=1.
- Back-to-back overflow:
  - Stimulus: 6 pushes on consecutive cycles with no sensor acks yet.
  - Required: first entry is popped; coin_inhibit rises once 4 entries are queued; at least one drop sets ovf=1; all remaining queued entries are served in order once acks arrive.
- Timeout:
  - Stimulus: no drop_sensor after DRINK.
  - Required: exactly 64 cycles in WAIT_DROP, then fault=1 with motors 0.
  - Stimulus: a push while in FAULT, then clr_fault.
  - Required: push is accepted while in FAULT; after clr_fault the queued entry is dispensed; served_cnt unchanged by the failed entry.
- Early ack plus reset:
  - Stimulus: drop_sensor asserted during DRINK.
  - Required: FSM leaves WAIT_DROP on its first cycle.
  - Stimulus: assert rst_=0 mid-CHANGE.
  - Required: coin_motor drops asynchronously, FIFO empty, served_cnt=0.
- Wrap:
  - Stimulus: 256 successful dispenses.
  - Required: served_cnt returns to 0.
